// File: rtl/sha512_pkg.sv
// Shared types, constants and small-sigma helpers for the SHA-512 message schedule.
package sha512_pkg;

  typedef logic [63:0] word_t;
  typedef logic [6:0]  round_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_DONE
  } sched_state_e;

  localparam int NUM_ROUNDS = 80;
  localparam int LOAD_WORDS = 16;

  // s0(x) = ROTR1 ^ ROTR8 ^ SHR7, rotations written as fixed concatenations
  function automatic word_t sigma0_small(input word_t x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  // s1(x) = ROTR19 ^ ROTR61 ^ SHR6
  function automatic word_t sigma1_small(input word_t x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

endpackage

// File: rtl/sha512_sched_adder.sv
// Combinational schedule-word generator: s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^64.
module sha512_sched_adder
  import sha512_pkg::*;
(
  input  logic [63:0] w_2_i,
  input  logic [63:0] w_7_i,
  input  logic [63:0] w_15_i,
  input  logic [63:0] w_16_i,
  output logic [63:0] sum_o
);

  assign sum_o = sigma1_small(w_2_i) + w_7_i + sigma0_small(w_15_i) + w_16_i;

endmodule

// File: rtl/sha512_sched_ctrl.sv
// SHA-512 message-schedule controller: loads W[0..15] from a stream, expands W[16..79].
// Optional macro SCHED_STALL_EN adds an exp_stall input that pauses expansion.
module sha512_sched_ctrl
  import sha512_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        msg_valid,
  input  logic [63:0] msg_word,
  output logic        msg_ready,
  input  logic [63:0] w_2,
  input  logic [63:0] w_7,
  input  logic [63:0] w_15,
  input  logic [63:0] w_16,
  output logic [6:0]  mem_round,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        sched_done,
  input  logic        blk_ack
`ifdef SCHED_STALL_EN
  ,
  input  logic        exp_stall
`endif
);

  sched_state_e state_q;
  round_t       round_q;
  logic         ready_q;
  logic         busy_q;
  logic         done_q;

  logic         stall;
  logic         loadHs;
  logic         expWrite;
  word_t        expWord;

`ifdef SCHED_STALL_EN
  assign stall = exp_stall;
`else
  assign stall = 1'b0;
`endif

  sha512_sched_adder u_adder (
    .w_2_i  (w_2),
    .w_7_i  (w_7),
    .w_15_i (w_15),
    .w_16_i (w_16),
    .sum_o  (expWord)
  );

  assign loadHs   = (state_q == S_LOAD) && msg_valid && ready_q;
  assign expWrite = (state_q == S_EXPAND) && !stall;

  // Write strobe and data follow the handshake in the same cycle, so they stay combinational.
  always_comb begin
    mem_we    = loadHs || expWrite;
    mem_wdata = '0;
    if (loadHs) begin
      mem_wdata = msg_word;
    end else if (state_q == S_EXPAND) begin
      mem_wdata = expWord;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            round_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (loadHs) begin
            round_q <= round_q + 7'd1;
            if (round_q == round_t'(LOAD_WORDS - 1)) begin
              state_q <= S_EXPAND;
              ready_q <= 1'b0;
            end
          end
        end
        S_EXPAND: begin
          if (!stall) begin
            if (round_q == round_t'(NUM_ROUNDS - 1)) begin
              state_q <= S_DONE;
              round_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              round_q <= round_q + 7'd1;
            end
          end
        end
        S_DONE: begin
          // blk_ack alone decides the exit; a coincident start is dropped
          if (blk_ack) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          round_q <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign msg_ready  = ready_q;
  assign mem_round  = round_q;
  assign busy       = busy_q;
  assign sched_done = done_q;

endmodule
